tetromino_bag_picker: RTL

//  Consumer side of the LFSR random stream. Turns raw random_i bits into a fair 7-bag

---
 rtl/tetromino_bag_picker_if.sv | 26 ++
 rtl/tetromino_bag_picker.sv | 86 ++++++++
 2 files changed

// File: rtl/tetromino_bag_picker_if.sv
// Bus bundle between the 7-bag picker and its consumers: random input, pop handshake,
// head piece and preview window.
interface tetromino_bag_picker_if #(
  parameter int rand_width_p = 65,
  parameter int depth_p      = 3
);
  localparam int CW = $clog2(depth_p + 1);

  logic [rand_width_p-1:0] random_i;
  logic                    flush_i;
  logic                    ready_i;
  logic                    valid_o;
  logic [2:0]              piece_o;
  logic [3*depth_p-1:0]    preview_o;
  logic [CW-1:0]           count_o;

  modport master (
    input  random_i, flush_i, ready_i,
    output valid_o, piece_o, preview_o, count_o
  );

  modport slave (
    output random_i, flush_i, ready_i,
    input  valid_o, piece_o, preview_o, count_o
  );
endinterface

// File: rtl/tetromino_bag_picker.sv
// Fair 7-bag tetromino picker: filters a raw random stream into a preview queue where
// every run of 7 pieces holds IDs 0..6 once each.
module tetromino_bag_picker #(
  parameter int rand_width_p = 65,
  parameter int depth_p      = 3,
  parameter int max_tries_p  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  tetromino_bag_picker_if.master bus
);
  localparam int CW = $clog2(depth_p + 1);
  localparam int RW = $clog2(max_tries_p + 1);

  logic [depth_p-1:0][2:0] slots, slots_nxt;
  logic [CW-1:0]           count, count_nxt, wr_idx;
  logic [6:0]              bag, bag_nxt, bag_left;
  logic [7:0]              bag8;
  logic [RW-1:0]           retry, retry_nxt;
  logic [2:0]              cand, low, pick;
  logic                    draw, forced, cand_ok, push, pop;
  logic                    unused_rand;

  assign unused_rand = ^bus.random_i[rand_width_p-1:3];

  assign cand    = bus.random_i[2:0];
  assign bag8    = {1'b0, bag};
  assign draw    = (count < CW'(depth_p));
  assign forced  = (retry == RW'(max_tries_p));
  assign cand_ok = (cand != 3'd7) && bag8[cand];
  assign pick    = forced ? low : cand;
  assign push    = draw && (forced || cand_ok);
  assign pop     = (count != '0) && bus.ready_i;
  assign wr_idx  = count - CW'(pop);

  always_comb begin
    low = 3'd0;
    for (int i = 6; i >= 0; i--)
      if (bag[i]) low = 3'(i);
  end

  // Shift toward the head on pop, then the tail write lands on the slot freed by it.
  always_comb begin
    slots_nxt = slots;
    for (int k = 0; k < depth_p - 1; k++)
      if (pop) slots_nxt[k] = slots[k+1];
    if (pop) slots_nxt[depth_p-1] = 3'd7;
    if (push)
      for (int k = 0; k < depth_p; k++)
        if (CW'(k) == wr_idx) slots_nxt[k] = pick;
  end

  always_comb begin
    bag_left  = bag & ~(7'b1 << pick);
    bag_nxt   = bag;
    if (push) bag_nxt = (bag_left == 7'h00) ? 7'h7F : bag_left;
    retry_nxt = retry;
    if (push)      retry_nxt = '0;
    else if (draw) retry_nxt = retry + RW'(1);
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slots <= '1;
      count <= '0;
      bag   <= 7'h7F;
      retry <= '0;
    end else if (bus.flush_i) begin
      slots <= '1;
      count <= '0;
      bag   <= 7'h7F;
      retry <= '0;
    end else begin
      slots <= slots_nxt;
      count <= count_nxt;
      bag   <= bag_nxt;
      retry <= retry_nxt;
    end
  end

  assign bus.preview_o = slots;
  assign bus.piece_o   = slots[0];
  assign bus.count_o   = count;
  assign bus.valid_o   = (count != '0);
endmodule
